// File: rtl/ram2_ctrl_pkg.sv
// ram2_ctrl_pkg: shared widths, RAM enable encodings and RAM2 controller state encodings.
package ram2_ctrl_pkg;
  localparam int DATA_BUS = 32;
  localparam int DATA_ADDR_BUS = 32;
  localparam logic RAM_CHIP_ENABLE = 1'b1;
  localparam logic RAM_CHIP_DISABLE = 1'b0;
  localparam logic READ_ENABLE = 1'b1;
  localparam logic READ_DISABLE = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  typedef enum logic [1:0] {RAM2_IDLE, RAM2_RD, RAM2_WR, RAM2_DONE} ram2_state_e;
endpackage

// File: rtl/ram2_ctrl_byte_merge.sv
// byte_merge: per-lane select of new bytes over old ones; sel[3] owns bits 31:24.
module byte_merge
  import ram2_ctrl_pkg::*;
(
  input  logic [DATA_BUS-1:0] old_word,
  input  logic [DATA_BUS-1:0] new_word,
  input  logic [3:0]          sel,
  output logic [DATA_BUS-1:0] merged
);
  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign merged[8*b +: 8] = sel[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
  end
endmodule

// File: rtl/ram2_ctrl.sv
// ram2_ctrl: MEM-stage to RAM2 bridge; stalls the pipeline while reads, writes and
// read-modify-write partial stores are carried out.
module ram2_ctrl
  import ram2_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_ce_i,
  input  logic                     mem_we_i,
  input  logic [DATA_ADDR_BUS-1:0] mem_addr_i,
  input  logic [3:0]               mem_sel_i,
  input  logic [DATA_BUS-1:0]      mem_data_i,
  output logic [DATA_BUS-1:0]      mem_data_o,
  output logic                     stallreq_o,
  output logic                     ram_ce_o,
  output logic                     ram_re_o,
  output logic                     ram_we_o,
  output logic [DATA_ADDR_BUS-1:0] ram_addr_o,
  output logic [DATA_BUS-1:0]      ram_data_o,
  input  logic [DATA_BUS-1:0]      ram_data_i
);
  ram2_state_e state;
  logic [11:0] addr_q;
  logic we_q;
  logic [3:0] sel_q;
  logic [DATA_BUS-1:0] data_q;
  logic [DATA_BUS-1:0] rdata_q;
  logic [DATA_BUS-1:0] merged;
  logic active;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr_i[31:14], mem_addr_i[1:0]};
  byte_merge u_merge (
    .old_word(rdata_q),
    .new_word(data_q),
    .sel(sel_q),
    .merged(merged)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RAM2_IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      sel_q <= '0;
      data_q <= '0;
      rdata_q <= '0;
      mem_data_o <= '0;
    end else begin
      case (state)
        RAM2_IDLE: if (mem_ce_i) begin
          addr_q <= mem_addr_i[13:2];
          we_q <= mem_we_i;
          sel_q <= mem_sel_i;
          data_q <= mem_data_i;
          // partial writes read the old word first; an empty write touches no RAM
          state <= !mem_we_i ? RAM2_RD : mem_sel_i == 4'hF ? RAM2_WR :
                   mem_sel_i == 4'h0 ? RAM2_DONE : RAM2_RD;
          if (mem_we_i && mem_sel_i == 4'h0) mem_data_o <= '0;
        end
        RAM2_RD: begin
          rdata_q <= ram_data_i;
          state <= we_q ? RAM2_WR : RAM2_DONE;
          if (!we_q) mem_data_o <= ram_data_i;
        end
        RAM2_WR: begin
          state <= RAM2_DONE;
          mem_data_o <= '0;
        end
        default: state <= RAM2_IDLE;
      endcase
    end
  end
  assign active = state == RAM2_RD || state == RAM2_WR;
  assign stallreq_o = rst ? 1'b0 : state == RAM2_IDLE ? mem_ce_i : active;
  assign ram_ce_o = active ? RAM_CHIP_ENABLE : RAM_CHIP_DISABLE;
  assign ram_re_o = state == RAM2_RD ? READ_ENABLE : READ_DISABLE;
  assign ram_we_o = state == RAM2_WR ? WRITE_ENABLE : WRITE_DISABLE;
  assign ram_addr_o = active ? {20'b0, addr_q} : '0;
  assign ram_data_o = state == RAM2_WR ? merged : '0;
endmodule

// File: tb/tb_ram2_ctrl.sv
// tb_ram2_ctrl: directed requests against a behavioural RAM2; a monitor pops expected
// read data and stall lengths from a queue each time an access completes.
module tb_ram2_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_ce_i = 1'b0;
  logic mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [3:0] mem_sel_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [31:0] mem_data_o;
  logic stallreq_o;
  logic ram_ce_o, ram_re_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;

  typedef struct {
    logic [31:0] data;
    int stalls;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [0:4095];
  logic pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic unused_hi;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int done_cnt = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int ce_cnt = 0;
  logic [31:0] last_wdata = '0;

  ram2_ctrl dut (
    .clk(clk),
    .rst(rst),
    .mem_ce_i(mem_ce_i),
    .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i),
    .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o),
    .stallreq_o(stallreq_o),
    .ram_ce_o(ram_ce_o),
    .ram_re_o(ram_re_o),
    .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i)
  );

  always #5 clk = ~clk;

  assign ram_data_i = mem[ram_addr_o[11:0]];
  assign unused_hi = ^ram_addr_o[31:12];
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_ce_o && ram_we_o) mem[ram_addr_o[11:0]] <= ram_data_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst) stall_cnt = 0;
    else begin
      if (ram_ce_o && ram_we_o) begin
        we_cnt++;
        last_wdata = ram_data_o;
      end
      if (ram_ce_o && ram_re_o) re_cnt++;
      if (ram_ce_o) ce_cnt++;
      if (stallreq_o) stall_cnt++;
      else if (stall_cnt > 0) begin
        check("done_has_expectation", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("mem_data_o", mem_data_o, e.data);
          check("stall_cycles", stall_cnt, e.stalls);
        end
        stall_cnt = 0;
        done_cnt++;
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                     input logic [31:0] data, input logic [31:0] exp, input int stalls,
                     input bit keep);
    int start;
    bit got;
    start = done_cnt;
    got = 1'b0;
    exp_q.push_back('{exp, stalls});
    mem_ce_i = 1'b1;
    mem_we_i = we;
    mem_addr_i = addr;
    mem_sel_i = sel;
    mem_data_i = data;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1 got = done_cnt != start;
    end
    if (!got) check("done_timeout", done_cnt, start + 1);
    if (!keep) mem_ce_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int w0, r0, c0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_data_o", mem_data_o, 32'h0);
    check("rst_stallreq_o", stallreq_o, 1'b0);
    check("rst_ram_enables", {ram_ce_o, ram_re_o, ram_we_o}, 3'b000);
    check("rst_ram_addr_o", ram_addr_o, 32'h0);
    rst = 1'b0;
    preload(12'h010, 32'h11223344);
    req(1'b0, 32'h40, 4'hF, 32'h0, 32'h11223344, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("hold_mem_data_o", mem_data_o, 32'h11223344);
    w0 = we_cnt; r0 = re_cnt;
    req(1'b1, 32'h44, 4'hF, 32'hDEADBEEF, 32'h0, 2, 1'b0);
    check("full_we_pulses", we_cnt - w0, 1);
    check("full_no_re", re_cnt - r0, 0);
    check("full_wdata", last_wdata, 32'hDEADBEEF);
    req(1'b0, 32'h44, 4'hF, 32'h0, 32'hDEADBEEF, 2, 1'b0);
    w0 = we_cnt; r0 = re_cnt;
    req(1'b1, 32'h44, 4'b0010, 32'h0000AB00, 32'h0, 3, 1'b0);
    check("partial_we_pulses", we_cnt - w0, 1);
    check("partial_re_pulses", re_cnt - r0, 1);
    check("partial_merged", last_wdata, 32'hDEADABEF);
    req(1'b0, 32'h44, 4'hF, 32'h0, 32'hDEADABEF, 2, 1'b0);
    c0 = ce_cnt;
    req(1'b1, 32'h44, 4'h0, 32'hFFFFFFFF, 32'h0, 1, 1'b0);
    check("sel0_no_ce", ce_cnt - c0, 0);
    check("sel0_ram_unchanged", mem[12'h011], 32'hDEADABEF);
    req(1'b0, 32'hFFFFC047, 4'hF, 32'h0, 32'hDEADABEF, 2, 1'b0);
    // abort a read-modify-write while it sits in its read cycle
    preload(12'h012, 32'hCAFEF00D);
    w0 = we_cnt;
    mem_ce_i = 1'b1;
    mem_we_i = 1'b1;
    mem_addr_i = 32'h48;
    mem_sel_i = 4'b0001;
    mem_data_i = 32'h000000FF;
    @(posedge clk);
    #1 check("abort_in_rd", ram_re_o, 1'b1);
    rst = 1'b1;
    #1 mem_ce_i = 1'b0;
    check("abort_stallreq_o", stallreq_o, 1'b0);
    check("abort_ram_enables", {ram_ce_o, ram_re_o, ram_we_o}, 3'b000);
    check("abort_mem_data_o", mem_data_o, 32'h0);
    check("abort_ram_addr_o", ram_addr_o, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_we", we_cnt - w0, 0);
    check("abort_ram_unchanged", mem[12'h012], 32'hCAFEF00D);
    req(1'b0, 32'h40, 4'hF, 32'h0, 32'h11223344, 2, 1'b1);
    req(1'b1, 32'h4C, 4'hF, 32'h12345678, 32'h0, 2, 1'b1);
    req(1'b0, 32'h4C, 4'hF, 32'h0, 32'h12345678, 2, 1'b0);
    repeat (2) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
